adc_spi_responder: RTL and testbench

- Synthesizable SPI responder emulating the 12-bit serial ADC that the oscilloscope's ADC interface drives (ADC_CS_N, ADC_SCLK, ADC_DIN in; ADC_DOUT out).
- Used for on-board loopback and simulation. It captures the 6-bit config word the master shifts in and returns a 12-bit sample MSB-first.
- The sample comes either from an external port or from an internal ramp generator.
- All SPI inputs are oversampled in the CLK domain; no logic is clocked by ADC_SCLK.

---
 rtl/adc_spi_responder.sv | 194 +++++++++++++++++++
 tb/tb_adc_spi_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: emulates a 12-bit serial ADC on a 4-wire SPI link.
// Every SPI pin is oversampled in the CLK domain. The design captures a config
// word from ADC_DIN and shifts a sample out on ADC_DOUT, MSB first. The sample
// comes from an external port or from an internal ramp.
module adc_spi_responder #(
  parameter int unsigned DATA_BITS = 12,
  parameter int unsigned CFG_BITS  = 6,
  parameter int unsigned RAMP_STEP = 1
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 ADC_CS_N,
  input  logic                 ADC_SCLK,
  input  logic                 ADC_DIN,
  output logic                 ADC_DOUT,
  input  logic [DATA_BITS-1:0] sample_data,
  input  logic                 use_ramp,
  output logic [CFG_BITS-1:0]  cfg_word,
  output logic                 cfg_valid,
  output logic                 frame_abort,
  output logic                 busy,
  output logic [15:0]          frame_cnt
);

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned FCNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Synchronizer and edge-detect flops
  logic r_cs_s1, r_cs_s2, r_cs_d;
  logic r_sck_s1, r_sck_s2, r_sck_d;
  logic r_din_s1, r_din_s2;

  // Frame state and registered outputs
  state_t               r_state,      w_state_nxt;
  logic [DATA_BITS-1:0] r_tx,         w_tx_nxt;
  logic [CFG_BITS-1:0]  r_rx,         w_rx_nxt;
  logic [CNT_W-1:0]     r_rx_cnt,     w_rx_cnt_nxt;
  logic [CNT_W-1:0]     r_tx_cnt,     w_tx_cnt_nxt;
  logic [CFG_BITS-1:0]  r_cfg_word,   w_cfg_word_nxt;
  logic                 r_cfg_valid,  w_cfg_valid_nxt;
  logic                 r_abort,      w_abort_nxt;
  logic                 r_busy,       w_busy_nxt;
  logic [FCNT_W-1:0]    r_frame_cnt,  w_frame_cnt_nxt;
  logic [DATA_BITS-1:0] r_ramp,       w_ramp_nxt;

  logic                 w_cs_fall, w_cs_rise, w_sck_rise, w_sck_fall;
  logic [CNT_W-1:0]     w_rx_cnt_inc, w_tx_cnt_inc;
  logic [DATA_BITS-1:0] w_load;

  // Two-flop synchronizers plus one edge-detect stage; CS_N idles high
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_cs_s1  <= 1'b1;
      r_cs_s2  <= 1'b1;
      r_cs_d   <= 1'b1;
      r_sck_s1 <= 1'b0;
      r_sck_s2 <= 1'b0;
      r_sck_d  <= 1'b0;
      r_din_s1 <= 1'b0;
      r_din_s2 <= 1'b0;
    end else begin
      r_cs_s1  <= ADC_CS_N;
      r_cs_s2  <= r_cs_s1;
      r_cs_d   <= r_cs_s2;
      r_sck_s1 <= ADC_SCLK;
      r_sck_s2 <= r_sck_s1;
      r_sck_d  <= r_sck_s2;
      r_din_s1 <= ADC_DIN;
      r_din_s2 <= r_din_s1;
    end
  end

  assign w_cs_fall  =  r_cs_d  & ~r_cs_s2;
  assign w_cs_rise  = ~r_cs_d  &  r_cs_s2;
  assign w_sck_rise = ~r_sck_d &  r_sck_s2;
  assign w_sck_fall =  r_sck_d & ~r_sck_s2;

  assign w_rx_cnt_inc = (r_rx_cnt == CNT_MAX) ? r_rx_cnt : r_rx_cnt + CNT_W'(1);
  assign w_tx_cnt_inc = (r_tx_cnt == CNT_MAX) ? r_tx_cnt : r_tx_cnt + CNT_W'(1);
  assign w_load       = use_ramp ? r_ramp : sample_data;

  // State and frame register bank
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_tx        <= '0;
      r_rx        <= '0;
      r_rx_cnt    <= '0;
      r_tx_cnt    <= '0;
      r_cfg_word  <= '0;
      r_cfg_valid <= 1'b0;
      r_abort     <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
      r_ramp      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_tx        <= w_tx_nxt;
      r_rx        <= w_rx_nxt;
      r_rx_cnt    <= w_rx_cnt_nxt;
      r_tx_cnt    <= w_tx_cnt_nxt;
      r_cfg_word  <= w_cfg_word_nxt;
      r_cfg_valid <= w_cfg_valid_nxt;
      r_abort     <= w_abort_nxt;
      r_busy      <= w_busy_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_ramp      <= w_ramp_nxt;
    end
  end

  // Next-state logic. ADC_DOUT is the MSB of the TX register, which is held at
  // zero whenever no data bit is being presented.
  always_comb begin
    w_state_nxt     = r_state;
    w_tx_nxt        = r_tx;
    w_rx_nxt        = r_rx;
    w_rx_cnt_nxt    = r_rx_cnt;
    w_tx_cnt_nxt    = r_tx_cnt;
    w_cfg_word_nxt  = r_cfg_word;
    w_cfg_valid_nxt = 1'b0;
    w_abort_nxt     = 1'b0;
    w_busy_nxt      = r_busy;
    w_frame_cnt_nxt = r_frame_cnt;
    w_ramp_nxt      = r_ramp;

    case (r_state)
      ST_IDLE: begin
        w_tx_nxt   = '0;
        w_busy_nxt = 1'b0;
        if (w_cs_fall) begin
          w_tx_nxt     = w_load;
          w_rx_nxt     = '0;
          w_rx_cnt_nxt = '0;
          w_tx_cnt_nxt = '0;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (w_cs_rise) begin
          // End of frame wins over any coincident SCLK edge
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_tx_nxt    = '0;
          if (r_rx_cnt >= CNT_W'(CFG_BITS)) begin
            w_cfg_word_nxt  = r_rx;
            w_cfg_valid_nxt = 1'b1;
            w_frame_cnt_nxt = r_frame_cnt + FCNT_W'(1);
            w_ramp_nxt      = r_ramp + DATA_BITS'(RAMP_STEP);
          end else begin
            w_abort_nxt = 1'b1;
          end
        end else begin
          if (w_sck_rise) begin
            // Only the first CFG_BITS bits are kept; first bit ends in the MSB
            if (r_rx_cnt < CNT_W'(CFG_BITS)) begin
              w_rx_nxt = {r_rx[CFG_BITS-2:0], r_din_s2};
            end
            w_rx_cnt_nxt = w_rx_cnt_inc;
          end
          if (w_sck_fall) begin
            w_tx_cnt_nxt = w_tx_cnt_inc;
            if (w_tx_cnt_inc < CNT_W'(DATA_BITS)) begin
              w_tx_nxt = {r_tx[DATA_BITS-2:0], 1'b0};
            end else begin
              w_tx_nxt = '0;
            end
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign ADC_DOUT    = r_tx[DATA_BITS-1];
  assign cfg_word    = r_cfg_word;
  assign cfg_valid   = r_cfg_valid;
  assign frame_abort = r_abort;
  assign busy        = r_busy;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: drives SPI master frames at CLK/10 and compares the
// returned sample bits and the status outputs against a frame-level model.
module tb_adc_spi_responder;

  logic        CLK = 1'b0;
  logic        reset;
  logic        ADC_CS_N;
  logic        ADC_SCLK;
  logic        ADC_DIN;
  logic        ADC_DOUT;
  logic [11:0] sample_data;
  logic        use_ramp;
  logic [5:0]  cfg_word;
  logic        cfg_valid;
  logic        frame_abort;
  logic        busy;
  logic [15:0] frame_cnt;

  localparam int HP = 5;  // SCLK half period in CLK cycles

  int n_assert = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_abort  = 0;

  // Frame-level model of the responder state
  int         m_ramp = 0;
  int         m_fcnt = 0;
  logic [5:0] m_cfg  = '0;

  adc_spi_responder dut (
    .CLK         (CLK),
    .reset       (reset),
    .ADC_CS_N    (ADC_CS_N),
    .ADC_SCLK    (ADC_SCLK),
    .ADC_DIN     (ADC_DIN),
    .ADC_DOUT    (ADC_DOUT),
    .sample_data (sample_data),
    .use_ramp    (use_ramp),
    .cfg_word    (cfg_word),
    .cfg_valid   (cfg_valid),
    .frame_abort (frame_abort),
    .busy        (busy),
    .frame_cnt   (frame_cnt)
  );

  always #5 CLK = ~CLK;

  // Count status pulses, sampled on the inactive edge
  always @(negedge CLK) begin
    if (cfg_valid)   n_valid++;
    if (frame_abort) n_abort++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b1; ADC_CS_N = 1'b1; ADC_SCLK = 1'b0; ADC_DIN = 1'b0;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    repeat (3) @(negedge CLK);
    m_ramp = 0; m_fcnt = 0; m_cfg = '0;
  endtask

  // One master frame of n SCLK periods; din[15] is sent first. The master
  // samples DOUT just before each rising SCLK edge.
  task automatic run_frame(input int n, input logic [15:0] din, input int chg_at,
                           input logic [11:0] chg_val, output logic [15:0] got,
                           output logic busy_mid);
    got = '0;
    @(negedge CLK);
    ADC_CS_N = 1'b0; ADC_DIN = din[15];
    repeat (HP) @(negedge CLK);
    for (int i = 0; i < n; i++) begin
      if (i == chg_at) sample_data = chg_val;
      got[15-i] = ADC_DOUT;
      ADC_SCLK = 1'b1;
      repeat (HP) @(negedge CLK);
      ADC_SCLK = 1'b0;
      if (i < 15) ADC_DIN = din[14-i];
      else        ADC_DIN = 1'b0;
      repeat (HP) @(negedge CLK);
    end
    busy_mid = busy;
    ADC_CS_N = 1'b1;
    repeat (HP + 3) @(negedge CLK);
  endtask

  // Run a frame and compare everything against the model
  task automatic frame_check(input string tag, input int n, input logic [15:0] din,
                             input logic ur, input logic [11:0] sd,
                             input int chg_at, input logic [11:0] chg_val);
    logic [11:0] exp_s;
    logic [15:0] got, mask;
    logic        busy_mid;
    int          v0, a0;
    logic        complete;
    use_ramp    = ur;
    sample_data = sd;
    exp_s    = ur ? 12'(m_ramp) : sd;
    complete = (n >= 6);
    v0 = n_valid; a0 = n_abort;
    run_frame(n, din, chg_at, chg_val, got, busy_mid);
    mask = ~(16'hFFFF >> n);
    if (complete) begin
      m_cfg  = din[15:10];
      m_fcnt = (m_fcnt + 1) % 65536;
      m_ramp = (m_ramp + 1) % 4096;
    end
    check({tag, ":dout_bits"},   32'(got),               32'({exp_s, 4'h0} & mask));
    check({tag, ":busy_mid"},    32'(busy_mid),          32'(1));
    check({tag, ":valid_pulse"}, 32'(n_valid - v0),      32'(complete ? 1 : 0));
    check({tag, ":abort_pulse"}, 32'(n_abort - a0),      32'(complete ? 0 : 1));
    check({tag, ":cfg_word"},    32'(cfg_word),          32'(m_cfg));
    check({tag, ":frame_cnt"},   32'(frame_cnt),         32'(m_fcnt));
    check({tag, ":idle"},        32'({busy, ADC_DOUT}),  32'(0));
  endtask

  initial begin
    logic [15:0] rnd_din;
    int          v0, a0;
    reset = 1'b1; ADC_CS_N = 1'b1; ADC_SCLK = 1'b0; ADC_DIN = 1'b0;
    sample_data = '0; use_ramp = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst:dout",      32'(ADC_DOUT),    32'(0));
    check("rst:busy",      32'(busy),        32'(0));
    check("rst:cfg_word",  32'(cfg_word),    32'(0));
    check("rst:frame_cnt", 32'(frame_cnt),   32'(0));
    check("rst:pulses",    32'({cfg_valid, frame_abort}), 32'(0));
    reset = 1'b0;
    repeat (4) @(negedge CLK);

    // External sample, config 100010 then zeros
    frame_check("ext_a5c", 16, {6'b100010, 10'b0}, 1'b0, 12'hA5C, -1, '0);

    // Ramp from reset: 0, 1, 2
    do_reset();
    for (int k = 0; k < 3; k++)
      frame_check($sformatf("ramp%0d", k), 16, 16'(k * 16'h1357), 1'b1, 12'h000, -1, '0);
    check("ramp:frame_cnt3", 32'(frame_cnt), 32'(3));

    // Ramp wrap: preload 4095, expect FFF then 000
    @(negedge CLK);
    force dut.r_ramp = 12'hFFF;
    repeat (2) @(negedge CLK);
    release dut.r_ramp;
    m_ramp = 4095;
    frame_check("wrap_fff", 16, 16'hF0F0, 1'b1, 12'h000, -1, '0);
    frame_check("wrap_000", 16, 16'h0F0F, 1'b1, 12'h000, -1, '0);

    // Short frame: 4 rises aborts, ramp not advanced
    frame_check("short4",     4, 16'hFFFF, 1'b1, 12'h000, -1, '0);
    frame_check("after_short", 16, 16'h2000, 1'b1, 12'h000, -1, '0);
    // Boundary: exactly CFG_BITS rises completes, one fewer aborts
    frame_check("edge6", 6, 16'hAC00, 1'b0, 12'h3C7, -1, '0);
    frame_check("edge5", 5, 16'h5400, 1'b0, 12'h3C7, -1, '0);

    // Sample changed mid-frame is ignored
    frame_check("midchg", 16, 16'h4400, 1'b0, 12'h123, 3, 12'hFFF);

    // Reset in the middle of a frame
    use_ramp = 1'b0; sample_data = 12'h5A5;
    @(negedge CLK);
    ADC_CS_N = 1'b0; ADC_DIN = 1'b1;
    repeat (HP) @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      ADC_SCLK = 1'b1; repeat (HP) @(negedge CLK);
      ADC_SCLK = 1'b0; repeat (HP) @(negedge CLK);
    end
    check("midrst:busy_before", 32'(busy), 32'(1));
    v0 = n_valid; a0 = n_abort;
    reset = 1'b1; ADC_CS_N = 1'b1;
    @(negedge CLK);
    check("midrst:dout",      32'(ADC_DOUT),  32'(0));
    check("midrst:busy",      32'(busy),      32'(0));
    check("midrst:frame_cnt", 32'(frame_cnt), 32'(0));
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    repeat (10) @(negedge CLK);
    check("midrst:no_pulses", 32'((n_valid - v0) + (n_abort - a0)), 32'(0));
    m_ramp = 0; m_fcnt = 0; m_cfg = '0;
    frame_check("post_rst_800", 16, 16'hB7E5, 1'b0, 12'h800, -1, '0);

    // Randomized frames: length, source, sample and DIN pattern
    for (int k = 0; k < 24; k++) begin
      rnd_din = 16'($urandom);
      frame_check($sformatf("rnd%0d", k), int'($urandom_range(0, 16)), rnd_din,
                  1'($urandom), 12'($urandom), -1, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
